// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM states, port indices,
// arbitration modes and default bus widths.
package dram_arbiter_pkg;

  localparam int AW_DEF = 11;
  localparam int DW_DEF = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CAPT  = 2'd3
  } state_t;

endpackage

// File: rtl/dram_arbiter_pick2.sv
// Two-way winner select: round-robin against the last winner, or port 0
// always first when mode is set.
module arb_pick2
  import dram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic mode,
  output logic any,
  output logic win
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    any = req0 | req1;
    win = PORT_CPU;
    if (req0 && req1) begin
      win = mode ? PORT_CPU : ~last;
    end else if (req1) begin
      win = PORT_AUX;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single data-BRAM port between the CPU (port 0) and an auxiliary
// master (port 1) using a req/gnt/done handshake; all outputs are registered.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,

  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  state_t     state;
  logic       last;
  logic       cur;
  logic       cur_we;
  logic [1:0] cnt;
  logic       any;
  logic       win;

  arb_pick2 u_pick (
    .req0 (r0_req),
    .req1 (r1_req),
    .last (last),
    .mode (PRIO_MODE == PRIO_FIXED),
    .any  (any),
    .win  (win)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= PORT_AUX;
      cur       <= PORT_CPU;
      cur_we    <= 1'b0;
      cnt       <= 2'd0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      case (state)
        // CAPT is the read done cycle and samples requests exactly like IDLE,
        // which lets a new grant follow a read with no bubble.
        IDLE, CAPT: begin
          r0_done <= 1'b0;
          r1_done <= 1'b0;
          if (any) begin
            cur       <= win;
            last      <= win;
            r0_gnt    <= (win == PORT_CPU);
            r1_gnt    <= (win == PORT_AUX);
            mem_addr  <= (win == PORT_AUX) ? r1_addr  : r0_addr;
            mem_wdata <= (win == PORT_AUX) ? r1_wdata : r0_wdata;
            mem_we    <= (win == PORT_AUX) ? r1_we    : r0_we;
            cur_we    <= (win == PORT_AUX) ? r1_we    : r0_we;
            state     <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end

        ISSUE: begin
          r0_gnt <= 1'b0;
          r1_gnt <= 1'b0;
          mem_we <= 1'b0;
          if (cur_we) begin
            r0_done <= (cur == PORT_CPU);
            r1_done <= (cur == PORT_AUX);
            state   <= IDLE;
          end else begin
            cnt   <= 2'(RD_LAT - 1);
            state <= WAIT;
          end
        end

        WAIT: begin
          if (cnt == 2'd0) begin
            if (cur == PORT_AUX) r1_rdata <= mem_rdata;
            else                 r0_rdata <= mem_rdata;
            r0_done <= (cur == PORT_CPU);
            r1_done <= (cur == PORT_AUX);
            state   <= CAPT;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: instance 0 is round-robin with RD_LAT=1,
// instance 1 is fixed priority with RD_LAT=3, each with its own model BRAM.
module tb_dram_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // [instance][port]
  logic          req    [2][2];
  logic          we_s   [2][2];
  logic [AW-1:0] addr_s [2][2];
  logic [DW-1:0] wd_s   [2][2];
  logic          gnt    [2][2];
  logic          done   [2][2];
  logic [DW-1:0] rd_s   [2][2];

  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wd   [2];
  logic          m_we   [2];
  logic [DW-1:0] rd_a, rd_b;

  dram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT_A), .PRIO_MODE(0)) u_a (
    .clk(clk), .rst(rst),
    .r0_req(req[0][0]), .r0_we(we_s[0][0]), .r0_addr(addr_s[0][0]), .r0_wdata(wd_s[0][0]),
    .r0_gnt(gnt[0][0]), .r0_done(done[0][0]), .r0_rdata(rd_s[0][0]),
    .r1_req(req[0][1]), .r1_we(we_s[0][1]), .r1_addr(addr_s[0][1]), .r1_wdata(wd_s[0][1]),
    .r1_gnt(gnt[0][1]), .r1_done(done[0][1]), .r1_rdata(rd_s[0][1]),
    .mem_addr(m_addr[0]), .mem_wdata(m_wd[0]), .mem_we(m_we[0]), .mem_rdata(rd_a)
  );

  dram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT_B), .PRIO_MODE(1)) u_b (
    .clk(clk), .rst(rst),
    .r0_req(req[1][0]), .r0_we(we_s[1][0]), .r0_addr(addr_s[1][0]), .r0_wdata(wd_s[1][0]),
    .r0_gnt(gnt[1][0]), .r0_done(done[1][0]), .r0_rdata(rd_s[1][0]),
    .r1_req(req[1][1]), .r1_we(we_s[1][1]), .r1_addr(addr_s[1][1]), .r1_wdata(wd_s[1][1]),
    .r1_gnt(gnt[1][1]), .r1_done(done[1][1]), .r1_rdata(rd_s[1][1]),
    .mem_addr(m_addr[1]), .mem_wdata(m_wd[1]), .mem_we(m_we[1]), .mem_rdata(rd_b)
  );

  // Model BRAMs, preset on reset to addr[7:0] ^ 0xBC (so 0x07F holds 0xC3).
  function automatic logic [DW-1:0] pat(int k);
    return 8'(k) ^ 8'hBC;
  endfunction

  logic [DW-1:0] mem_a [2**AW];
  logic [DW-1:0] mem_b [2**AW];
  logic [DW-1:0] b_p1, b_p2;

  always @(posedge clk) begin
    if (rst) for (int k = 0; k < 2**AW; k++) mem_a[k] <= pat(k);
    else if (m_we[0]) mem_a[m_addr[0]] <= m_wd[0];
    rd_a <= mem_a[m_addr[0]];
  end

  always @(posedge clk) begin
    if (rst) for (int k = 0; k < 2**AW; k++) mem_b[k] <= pat(k);
    else if (m_we[1]) mem_b[m_addr[1]] <= m_wd[1];
    b_p1 <= mem_b[m_addr[1]];
    b_p2 <= b_p1;
    rd_b <= b_p2;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(int i, string nm, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL inst%0d %s: got 0x%0h, expected 0x%0h", i, nm, act, exp);
  endtask

  task automatic fail(int i, string nm);
    n_checks++;
    $display("FAIL inst%0d %s", i, nm);
  endtask

  // Expected transactions per instance/port, and expected grant order per instance.
  exp_t q00[$], q01[$], q10[$], q11[$];
  int   go0[$], go1[$];

  function automatic int qsize(int i, int p);
    case (i * 2 + p)
      0:       return q00.size();
      1:       return q01.size();
      2:       return q10.size();
      default: return q11.size();
    endcase
  endfunction

  function automatic exp_t qpeek(int i, int p);
    case (i * 2 + p)
      0:       return q00[0];
      1:       return q01[0];
      2:       return q10[0];
      default: return q11[0];
    endcase
  endfunction

  task automatic qpush(int i, int p, exp_t e);
    case (i * 2 + p)
      0:       q00.push_back(e);
      1:       q01.push_back(e);
      2:       q10.push_back(e);
      default: q11.push_back(e);
    endcase
  endtask

  task automatic qpop(int i, int p, output exp_t e);
    case (i * 2 + p)
      0:       e = q00.pop_front();
      1:       e = q01.pop_front();
      2:       e = q10.pop_front();
      default: e = q11.pop_front();
    endcase
  endtask

  function automatic int gsize(int i);
    return (i == 0) ? go0.size() : go1.size();
  endfunction

  task automatic gpush(int i, int p);
    if (i == 0) go0.push_back(p);
    else        go1.push_back(p);
  endtask

  task automatic gpop(int i, output int p);
    if (i == 0) p = go0.pop_front();
    else        p = go1.pop_front();
  endtask

  // Monitor: compares grants and completions against the scoreboard.
  int gcyc [2][2];

  task automatic mon(int i, int lat);
    exp_t e;
    int   hi;
    int   gp;
    hi = int'(gnt[i][0]) + int'(gnt[i][1]) + int'(done[i][0]) + int'(done[i][1]);
    if (hi > 0 || m_we[i]) begin
      check(i, "one_pulse", hi, 1);
      check(i, "we_outside_issue", int'(m_we[i] & ~gnt[i][0] & ~gnt[i][1]), 0);
    end
    for (int p = 0; p < 2; p++) begin
      if (gnt[i][p]) begin
        if (gsize(i) == 0) fail(i, "gnt_unexpected");
        else begin
          gpop(i, gp);
          check(i, "gnt_order", p, gp);
        end
        if (qsize(i, p) == 0) fail(i, "gnt_without_txn");
        else begin
          e = qpeek(i, p);
          check(i, "mem_addr", int'(m_addr[i]), int'(e.addr));
          check(i, "mem_we", int'(m_we[i]), int'(e.we));
          if (e.we) check(i, "mem_wdata", int'(m_wd[i]), int'(e.wd));
        end
        gcyc[i][p] = cyc;
      end
      if (done[i][p]) begin
        if (qsize(i, p) == 0) fail(i, "done_unexpected");
        else begin
          qpop(i, p, e);
          check(i, "latency", cyc - gcyc[i][p], e.we ? 1 : lat + 1);
          if (!e.we) check(i, "rdata", int'(rd_s[i][p]), int'(e.rd));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, LAT_A);
    mon(1, LAT_B);
  end

  // Requester: drive, hold until gnt, then wait for done (both bounded).
  task automatic txn(int i, int p, logic w, logic [AW-1:0] a, logic [DW-1:0] d,
                     logic [DW-1:0] r);
    exp_t e;
    bit   seen;
    e.we = w; e.addr = a; e.wd = d; e.rd = r;
    qpush(i, p, e);
    we_s[i][p] = w; addr_s[i][p] = a; wd_s[i][p] = d; req[i][p] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = gnt[i][p];
    end
    req[i][p] = 1'b0;
    if (!seen) begin
      fail(i, "gnt_timeout");
      return;
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = done[i][p];
    end
    if (!seen) fail(i, "done_timeout");
  endtask

  task automatic check_reset_outputs(int i, string tag);
    check(i, {tag, "_ctl"}, int'({gnt[i][0], gnt[i][1], done[i][0], done[i][1], m_we[i]}), 0);
    check(i, {tag, "_mem_addr"}, int'(m_addr[i]), 0);
    check(i, {tag, "_mem_wdata"}, int'(m_wd[i]), 0);
    check(i, {tag, "_rdata"}, int'({rd_s[i][0], rd_s[i][1]}), 0);
  endtask

  initial begin
    exp_t e;
    bit   seen;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we_s[i][p] = 1'b0; addr_s[i][p] = '0; wd_s[i][p] = '0;
      end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "rst");
    check_reset_outputs(1, "rst");
    rst = 1'b0;
    @(negedge clk);

    // Round-robin tie with reads on both ports: port 0 first, then alternate.
    gpush(0, 0); gpush(0, 1); gpush(0, 0); gpush(0, 1);
    fork
      begin
        txn(0, 0, 1'b0, 11'h123, 8'h00, 8'h9F);
        txn(0, 0, 1'b0, 11'h124, 8'h00, 8'h98);
      end
      begin
        txn(0, 1, 1'b0, 11'h7FF, 8'h00, 8'h43);
        txn(0, 1, 1'b0, 11'h000, 8'h00, 8'hBC);
      end
    join

    // Single write then read on port 0.
    gpush(0, 0); gpush(0, 0);
    txn(0, 0, 1'b1, 11'h123, 8'h5A, 8'h00);
    txn(0, 0, 1'b0, 11'h123, 8'h00, 8'h5A);

    // last = 0 now: port 1's write wins the tie, port 0's read sees it.
    gpush(0, 1); gpush(0, 0);
    fork
      txn(0, 0, 1'b0, 11'h7FF, 8'h00, 8'hFF);
      txn(0, 1, 1'b1, 11'h7FF, 8'hFF, 8'h00);
    join
    repeat (2) @(negedge clk);
    check(0, "rdata_held", int'(rd_s[0][0]), 'hFF);

    // RD_LAT=3: the preceding access leaves a different word in the pipeline.
    gpush(1, 0); gpush(1, 0);
    txn(1, 0, 1'b1, 11'h010, 8'h11, 8'h00);
    txn(1, 0, 1'b0, 11'h07F, 8'h00, 8'hC3);

    // Fixed priority: port 0 back-to-back, port 1 waits until r0_req drops.
    gpush(1, 0); gpush(1, 0); gpush(1, 0); gpush(1, 1);
    fork
      begin
        txn(1, 0, 1'b1, 11'h200, 8'h01, 8'h00);
        txn(1, 0, 1'b1, 11'h201, 8'h02, 8'h00);
        txn(1, 0, 1'b0, 11'h200, 8'h00, 8'h01);
      end
      txn(1, 1, 1'b0, 11'h07F, 8'h00, 8'hC3);
    join

    // Reset while a port 0 read sits in WAIT: no done, outputs cleared.
    e.we = 1'b0; e.addr = 11'h7FF; e.wd = 8'h00; e.rd = 8'h00;
    qpush(0, 0, e);
    gpush(0, 0);
    we_s[0][0] = 1'b0; addr_s[0][0] = 11'h7FF; req[0][0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = gnt[0][0];
    end
    req[0][0] = 1'b0;
    if (!seen) fail(0, "rst_read_gnt_timeout");
    @(negedge clk);
    rst = 1'b1;
    qpop(0, 0, e);
    @(negedge clk);
    check_reset_outputs(0, "midrst");
    rst = 1'b0;

    // First tie after reset goes to port 0 again.
    gpush(0, 0); gpush(0, 1);
    fork
      txn(0, 0, 1'b0, 11'h123, 8'h00, 8'h9F);
      txn(0, 1, 1'b1, 11'h124, 8'h77, 8'h00);
    join
    gpush(0, 0);
    txn(0, 0, 1'b0, 11'h124, 8'h00, 8'h77);

    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check(i, "pending_txn", qsize(i, 0) + qsize(i, 1), 0);
      check(i, "pending_gnt", gsize(i), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
